// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 3-port register file with hardware clear sequencer, write bypass and busy scoreboard
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             ready,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr
);
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic run, hit1, hit2, wzero, rzero;
  assign run = state_q == RUN;
  assign ready = run;
  assign wzero = ZERO_REG != 0 && wa3 == '0;
  assign rzero = ZERO_REG != 0 && rsv_addr == '0;
  // a zero-register bypass hit is already covered by the raN==0 check
  assign hit1 = BYPASS != 0 && we3 && wa3 == ra1;
  assign hit2 = BYPASS != 0 && we3 && wa3 == ra2;
  assign rd1 = !run || (ZERO_REG != 0 && ra1 == '0) ? '0 : hit1 ? wd3 : rf_q[ra1];
  assign rd2 = !run || (ZERO_REG != 0 && ra2 == '0) ? '0 : hit2 ? wd3 : rf_q[ra2];
  assign rd1_busy = run && !hit1 && busy_q[ra1];
  assign rd2_busy = run && !hit2 && busy_q[ra2];
  always_comb begin
    state_d = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d = busy_q;
    wr_en = 1'b0;
    wr_addr = wa3;
    wr_data = wd3;
    if (!run) begin
      wr_en = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      state_d = clr_cnt_q == AW'(DEPTH - 1) ? RUN : INIT;
    end else if (clr_req) begin
      state_d = INIT;
      clr_cnt_d = '0;
      busy_d = '0;
    end else begin
      wr_en = we3 && !wzero;
      if (we3) busy_d[wa3] = 1'b0;
      // reservation applied last so a same-address set beats the clear
      if (rsv_en && !rzero) busy_d[rsv_addr] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      clr_cnt_q <= '0;
      busy_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) rf_q[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an abstract register/scoreboard model
module tb_regfile_sb;
  localparam int W = 32;
  localparam int D = 32;
  localparam int AW = 5;
  logic clk = 1'b0, rst_n, clr_req, ready, we3, rsv_en, rd1_busy, rd2_busy;
  logic [AW-1:0] ra1, ra2, wa3, rsv_addr;
  logic [W-1:0] rd1, rd2, wd3;
  int checks = 0, failures = 0, n;
  logic [W-1:0] rf_m [D];
  logic [D-1:0] busy_m;
  bit ready_m;
  int left_m;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .we3(we3), .wa3(wa3), .wd3(wd3), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) rf_m[i] = '0;
    busy_m = '0;
    ready_m = 0;
    left_m = D;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (!ready_m || a == 0) return '0;
    if (we3 && wa3 == a) return wd3;
    return rf_m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!ready_m || (we3 && wa3 == a)) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic rsv, input logic [AW-1:0] ra, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic clr);
    we3 = we; wa3 = wa; wd3 = wd; rsv_en = rsv; rsv_addr = ra; ra1 = a1; ra2 = a2; clr_req = clr;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    drive(0, 0, 0, 0, 0, a1, a2, 0);
  endtask

  // compare away from the edge, then advance the model alongside the DUT
  task automatic tick();
    @(negedge clk);
    check("ready", ready, ready_m);
    check("rd1", rd1, exp_rd(ra1));
    check("rd2", rd2, exp_rd(ra2));
    check("rd1_busy", rd1_busy, exp_busy(ra1));
    check("rd2_busy", rd2_busy, exp_busy(ra2));
    @(posedge clk);
    if (!ready_m) begin
      left_m--;
      if (left_m == 0) ready_m = 1;
    end else if (clr_req) begin
      model_clear();
    end else begin
      if (we3 && wa3 != 0) rf_m[wa3] = wd3;
      if (we3) busy_m[wa3] = 1'b0;
      if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 100) begin
      drive(1, 4, 32'h1111_1111, 1, 4, 4, 3, 1);
      tick();
      n++;
    end
    check(tag, n, D);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", ready, 0);
    check("rd1_in_reset", rd1, 0);
    rst_n = 1'b1;
    wait_ready("reset_latency");
    for (int i = 0; i < D; i++) begin
      idle(AW'(i), AW'(D - 1 - i));
      tick();
    end

    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0, 0);
    #1 check("bypass_same_cycle", rd1, 32'hDEAD_BEEF);
    tick();
    idle(5, 0);
    #1 check("read_after_write", rd1, 32'hDEAD_BEEF);
    tick();

    drive(1, 0, 32'h1234_5678, 1, 0, 0, 0, 0);
    tick();
    idle(0, 0);
    #1 check("zero_reg_data", rd1, 0);
    check("zero_reg_busy", rd1_busy, 0);
    tick();

    drive(0, 0, 0, 1, 7, 0, 7, 0);
    tick();
    idle(0, 7);
    #1 check("rsv_sets_busy", rd2_busy, 1);
    tick();
    drive(1, 7, 32'h7777_0000, 1, 7, 0, 7, 0);
    tick();
    idle(0, 7);
    #1 check("rsv_wins_same_addr", rd2_busy, 1);
    tick();
    drive(1, 7, 32'h7777_0001, 0, 0, 0, 7, 0);
    tick();
    idle(7, 7);
    #1 check("write_clears_busy", rd2_busy, 0);
    check("write_data_7", rd1, 32'h7777_0001);
    tick();

    drive(1, 3, 32'hA5A5_A5A5, 1, 9, 0, 0, 0);
    tick();
    idle(3, 9);
    #1 check("busy9_before_clr", rd2_busy, 1);
    tick();
    drive(1, 3, 32'hFFFF_FFFF, 1, 12, 3, 9, 1);
    tick();
    check("ready_low_after_clr", ready, 0);
    wait_ready("clr_latency");
    idle(3, 9);
    #1 check("reg3_cleared", rd1, 0);
    check("busy9_cleared", rd2_busy, 0);
    tick();
    idle(4, 12);
    #1 check("init_write_dropped", rd1, 0);
    check("init_rsv_dropped", rd2_busy, 0);
    tick();

    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    repeat (10) begin
      idle(1, 2);
      tick();
    end
    rst_n = 1'b0;
    model_clear();
    #1 check("ready_drops_async", ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("reset_mid_clear_latency");

    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] lo;
      lo = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      drive($urandom_range(0, 1), lo, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom),
            $urandom_range(0, 1) ? lo : AW'($urandom_range(0, 7)), AW'($urandom),
            $urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
